// File: rtl/encoder_fixed_point_seq.sv
// encoder_fixed_point_seq: M_OUTPUT parallel fixed-point MACs over N_INPUT cycles.
// Define ENCODER_RELU_EN to clamp negative results to zero after saturation.
module encoder_fixed_point_seq #(
  parameter int N_INPUT  = 9,
  parameter int M_OUTPUT = 4,
  parameter int BITSIZE  = 32,
  parameter int FRAC     = 26
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N_INPUT*BITSIZE-1:0]          x,
  input  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0] w,
  input  logic [M_OUTPUT*BITSIZE-1:0]         b,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [M_OUTPUT*BITSIZE-1:0]         out,
  output logic [M_OUTPUT-1:0]                 ovf,
  output logic                                busy
);
  localparam int CW = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
  localparam int AW = 2*BITSIZE + $clog2(N_INPUT) + 1;
  localparam int TW = AW + 1;
  localparam logic signed [TW-1:0] RND = (TW'(1) << FRAC) >> 1;
  localparam logic signed [TW-1:0] MAXV =
    {{(TW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [TW-1:0] MINV =
    {{(TW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

  state_t                      r_state;
  logic [CW-1:0]               r_cnt;
  logic signed [BITSIZE-1:0]   r_x [N_INPUT];
  logic signed [BITSIZE-1:0]   r_w [M_OUTPUT][N_INPUT];
  logic signed [BITSIZE-1:0]   r_b [M_OUTPUT];
  logic signed [AW-1:0]        r_acc [M_OUTPUT];
  logic [M_OUTPUT*BITSIZE-1:0] r_out;
  logic [M_OUTPUT-1:0]         r_ovf;
  logic                        r_out_valid;

  logic signed [2*BITSIZE-1:0] w_prod [M_OUTPUT];
  logic signed [TW-1:0]        w_t [M_OUTPUT];
  logic signed [TW-1:0]        w_s [M_OUTPUT];
  logic [BITSIZE-1:0]          w_sat [M_OUTPUT];
  logic [M_OUTPUT*BITSIZE-1:0] w_res;
  logic [M_OUTPUT-1:0]         w_ovf;
  logic                        w_accept;

  assign in_ready = !rst &&
    ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out       = r_out;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == ACCUM) || (r_state == FINAL);

  // Bias is aligned to the product scale before rounding.
  always_comb begin
    w_res = '0;
    w_ovf = '0;
    for (int j = 0; j < M_OUTPUT; j++) begin
      w_prod[j] = (2*BITSIZE)'(r_x[r_cnt]) *
                  (2*BITSIZE)'(r_w[j][r_cnt]);
      w_t[j] = TW'(r_acc[j]) + (TW'(r_b[j]) <<< FRAC) + RND;
      w_s[j] = w_t[j] >>> FRAC;
      if (w_s[j] > MAXV) begin
        w_sat[j] = {1'b0, {(BITSIZE-1){1'b1}}};
        w_ovf[j] = 1'b1;
      end else if (w_s[j] < MINV) begin
        w_sat[j] = {1'b1, {(BITSIZE-1){1'b0}}};
        w_ovf[j] = 1'b1;
      end else begin
        w_sat[j] = w_s[j][BITSIZE-1:0];
      end
`ifdef ENCODER_RELU_EN
      if (w_sat[j][BITSIZE-1]) w_sat[j] = '0;
`else
      w_sat[j] = w_sat[j];
`endif
      w_res[j*BITSIZE +: BITSIZE] = w_sat[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_INPUT; i++) r_x[i] <= '0;
      for (int j = 0; j < M_OUTPUT; j++) begin
        r_b[j] <= '0;
        for (int i = 0; i < N_INPUT; i++) r_w[j][i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < N_INPUT; i++)
        r_x[i] <= x[i*BITSIZE +: BITSIZE];
      for (int j = 0; j < M_OUTPUT; j++) begin
        r_b[j] <= b[j*BITSIZE +: BITSIZE];
        for (int i = 0; i < N_INPUT; i++)
          r_w[j][i] <= w[(j*N_INPUT+i)*BITSIZE +: BITSIZE];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_out       <= '0;
      r_ovf       <= '0;
      r_out_valid <= 1'b0;
      for (int j = 0; j < M_OUTPUT; j++) r_acc[j] <= '0;
    end else if (w_accept) begin
      r_state     <= ACCUM;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      for (int j = 0; j < M_OUTPUT; j++) r_acc[j] <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
        end
        ACCUM: begin
          for (int j = 0; j < M_OUTPUT; j++)
            r_acc[j] <= r_acc[j] + AW'(w_prod[j]);
          if (r_cnt == CW'(N_INPUT-1)) r_state <= FINAL;
          else r_cnt <= r_cnt + 1'b1;
        end
        FINAL: begin
          r_out       <= w_res;
          r_ovf       <= w_ovf;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/encoder_fixed_point_seq.md
Name: encoder_fixed_point_seq

Overview:
Sequential, parametrised successor to the combinational fixed-point encoder layer. Computes out[j] = sat(round(sum_i x[i]*w[j][i]) + b[j]) for M_OUTPUT lanes. It runs M_OUTPUT parallel MACs over N_INPUT cycles, and uses valid/ready handshakes on input and output. It sits between the feature source and the latent/decoder stage.

Parameters:
N_INPUT, 9, number of input features (>=1)
M_OUTPUT, 4, number of output lanes (>=1)
BITSIZE, 32, word width, two's-complement signed fixed point
FRAC, 26, fractional bits (default format 1 sign, 5 integer, 26 fraction)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  x/w/b bundle valid
in_ready  out  1  block can accept a bundle
x  in  N_INPUT*BITSIZE  inputs; x[i] at bits [i*BITSIZE +: BITSIZE]
w  in  N_INPUT*M_OUTPUT*BITSIZE  weights; w[j][i] at index j*N_INPUT+i
b  in  M_OUTPUT*BITSIZE  biases; b[j] at bits [j*BITSIZE +: BITSIZE]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out  out  M_OUTPUT*BITSIZE  results; out[j] at bits [j*BITSIZE +: BITSIZE]
ovf  out  M_OUTPUT  per-lane saturation flag, qualified by out_valid
busy  out  1  state is ACCUM or FINAL

Behaviour:
- Reset, asynchronous: state=IDLE, cnt=0, accumulators=0, out=0, ovf=0, out_valid=0. in_ready is forced 0 while rst is high.
- Reset mid-operation aborts the computation. The captured bundle is discarded and no out_valid is produced.
- FSM states: IDLE, ACCUM, FINAL, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept occurs when in_valid & in_ready. On accept, x/w/b are registered, accumulators are cleared, cnt=0, and the state moves to ACCUM.
- Inputs are ignored outside an accept. Changing x/w/b after an accept has no effect on the result.
- ACCUM: each cycle, acc[j] += x[cnt]*w[j][cnt]. The product is full precision, 2*BITSIZE signed.
- ACCUM exit: at cnt==N_INPUT-1 the state moves to FINAL; otherwise cnt increments.
- Accumulator width: 2*BITSIZE + clog2(N_INPUT) + 1. The accumulator never wraps.
- FINAL, per lane: t = acc[j] + (b[j] sign-extended, <<FRAC) + 2^(FRAC-1), then arithmetic shift right by FRAC (round half up).
- FINAL saturation: if t exceeds the BITSIZE signed range, out[j] = 0x7FFF..F or 0x8000..0 and ovf[j]=1; else ovf[j]=0.
- FINAL registers out and ovf, asserts out_valid, and moves to DONE.
- Latency: accept at edge k; out_valid is high after edge k+N_INPUT+1, i.e. 10 cycles for the defaults.
- DONE: out, ovf and out_valid are held stable until out_ready.
- DONE with out_ready & !in_valid: out_valid falls and the state returns to IDLE.
- DONE with out_ready & in_valid: the result is popped and the new bundle is accepted in the same cycle (next state ACCUM). out_valid falls, so there is no bubble beyond FINAL.
- out_ready outside DONE is ignored.

Optional Feature:
ENCODER_RELU_EN
- Defined: a ReLU is applied after saturation; any negative out[j] becomes 0. ovf still reports saturation before the ReLU, so negative saturation gives out=0 and ovf=1.
- Undefined: the signed saturated result is output unchanged.

Test Plan:
- Basic sum: all x=1.0 (0x04000000), all w=1.0, b=0, accept at edge 0.
  -> out_valid rises after edge 10; every out[j]=0x24000000 (9.0); ovf=0.
- Bias and negatives: x=-1.0 (0xFC000000), w=1.0, b[j]=j*1.0.
  -> Without RELU: out=-9,-8,-7,-6 (0xDC000000, 0xE0000000, 0xE4000000, 0xE8000000).
  -> With ENCODER_RELU_EN: all out=0.
- Saturation: x=31.0, w=31.0 on lane 0 and 0 on the other lanes.
  -> out[0]=0x7FFFFFFF, ovf=4'b0001.
  -> With lane 0 weights set to w=-31.0: out[0]=0x80000000.
- Rounding: x[0]=2^-26 (0x00000001), w[0][0]=0.5 (0x02000000), all else 0.
  -> out[0]=0x00000001 (0.5 LSB rounds up).
- Backpressure and overlap:
  -> Hold out_ready=0 for 5 cycles after out_valid: out stable, in_ready=0.
  -> Then assert out_ready and in_valid together: same-cycle pop and accept; next out_valid 10 cycles later.
- Reset mid-ACCUM: assert rst at cnt=4.
  -> out_valid stays 0, outputs are 0, in_ready=1 after deassert.
  -> A fresh bundle then completes correctly.
